keccak_rc_reverse_seq: RTL

//  Reverse-order Keccak round-constant sequencer. Walks the round-constant LFSR backwards and

---
 rtl/keccak_rc_reverse_seq.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/keccak_rc_reverse_seq.sv
// keccak_rc_reverse_seq
//   Reverse-order Keccak round-constant sequencer. It walks the round-constant
//   LFSR (x^8+x^6+x^5+x^4+1, s[i] = coefficient of x^i) forward to the state of
//   start_round. It then streams RC[start_round] down to RC[0] over a
//   valid/ready interface, stepping the LFSR backwards by 7 steps per beat.
//
// Parameters
//   NR    number of rounds; legal start_round is 0..NR-1
//   RC_W  lane width (8, 16 or 32)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        sweep request, sampled only when idle
//   start_round  first (highest) round index to emit
//   rc_ready     downstream accepts the current beat
//   rc_valid     rc / rc_round / rc_last are valid
//   rc           round constant for round rc_round
//   rc_round     round index of the current beat
//   rc_last      marks the round-0 beat
//   busy         sweep in progress
//   err          sticky error (illegal start, or self-check failure)
//
// Configuration
//   KECCAK_RC_SELFCHECK_EN  adds a CHECK cycle after the round-0 handshake that
//                           confirms the LFSR has returned to 8'h01.
module keccak_rc_reverse_seq #(
    parameter int NR   = 22,
    parameter int RC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      start_round,
    input  logic            rc_ready,
    output logic            rc_valid,
    output logic [RC_W-1:0] rc,
    output logic [4:0]      rc_round,
    output logic            rc_last,
    output logic            busy,
    output logic            err
);

    localparam int unsigned L = $clog2(RC_W);

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        EMIT
`ifdef KECCAK_RC_SELFCHECK_EN
        ,
        CHECK
`endif
    } state_t;

    state_t          state, state_n;
    logic [7:0]      s, s_n;
    logic [4:0]      cnt, cnt_n;
    logic [4:0]      first_round, first_round_n;
    logic            rc_valid_n;
    logic [RC_W-1:0] rc_n;
    logic [4:0]      rc_round_n;
    logic            rc_last_n;
    logic            err_n;

    logic [7:0]      s_fwd7;
    logic [7:0]      s_rev7;
    logic [RC_W-1:0] rc_cur;
    logic [RC_W-1:0] rc_prev;
    logic            start_legal;

    function automatic logic [7:0] fwd1(input logic [7:0] v);
        logic [7:0] r;
        logic       t;
        t    = v[7];
        r    = {v[6:0], 1'b0};
        r[0] = r[0] ^ t;
        r[4] = r[4] ^ t;
        r[5] = r[5] ^ t;
        r[6] = r[6] ^ t;
        return r;
    endfunction

    function automatic logic [7:0] rev1(input logic [7:0] v);
        logic [7:0] r;
        logic       t;
        t    = v[0];
        r    = v;
        r[4] = r[4] ^ t;
        r[5] = r[5] ^ t;
        r[6] = r[6] ^ t;
        return {t, r[7:1]};
    endfunction

    function automatic logic [7:0] fwd7(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        for (int unsigned i = 0; i < 7; i++) begin
            r = fwd1(r);
        end
        return r;
    endfunction

    function automatic logic [7:0] rev7(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        for (int unsigned i = 0; i < 7; i++) begin
            r = rev1(r);
        end
        return r;
    endfunction

    // Only bits 2^j-1 of the lane are ever set; bit j of the LFSR output
    // sequence starting at this state lands there.
    function automatic logic [RC_W-1:0] derive_rc(input logic [7:0] v);
        logic [RC_W-1:0] r;
        logic [7:0]      w;
        logic [L-1:0]    idx;
        r = '0;
        w = v;
        for (int unsigned j = 0; j <= L; j++) begin
            idx    = L'((32'd1 << j) - 32'd1);
            r[idx] = w[0];
            w      = fwd1(w);
        end
        return r;
    endfunction

    assign s_fwd7      = fwd7(s);
    assign s_rev7      = rev7(s);
    assign rc_cur      = derive_rc(s);
    assign rc_prev     = derive_rc(s_rev7);
    assign start_legal = ({27'd0, start_round} < 32'(NR));
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            s           <= 8'h01;
            cnt         <= '0;
            first_round <= '0;
            rc_valid    <= 1'b0;
            rc          <= '0;
            rc_round    <= '0;
            rc_last     <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            s           <= s_n;
            cnt         <= cnt_n;
            first_round <= first_round_n;
            rc_valid    <= rc_valid_n;
            rc          <= rc_n;
            rc_round    <= rc_round_n;
            rc_last     <= rc_last_n;
            err         <= err_n;
        end
    end

    always_comb begin
        state_n       = state;
        s_n           = s;
        cnt_n         = cnt;
        first_round_n = first_round;
        rc_valid_n    = rc_valid;
        rc_n          = rc;
        rc_round_n    = rc_round;
        rc_last_n     = rc_last;
        err_n         = err;

        case (state)
            IDLE: begin
                if (start) begin
                    if (start_legal) begin
                        s_n           = 8'h01;
                        cnt_n         = start_round;
                        first_round_n = start_round;
                        state_n       = SEEK;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            SEEK: begin
                if (cnt != 5'd0) begin
                    s_n   = s_fwd7;
                    cnt_n = cnt - 5'd1;
                end else begin
                    rc_n       = rc_cur;
                    rc_round_n = first_round;
                    rc_last_n  = (first_round == 5'd0);
                    rc_valid_n = 1'b1;
                    state_n    = EMIT;
                end
            end

            EMIT: begin
                if (rc_ready) begin
                    if (rc_round != 5'd0) begin
                        // Next beat is derived from the already-reversed state so
                        // consecutive handshakes need no bubble.
                        s_n        = s_rev7;
                        rc_n       = rc_prev;
                        rc_round_n = rc_round - 5'd1;
                        rc_last_n  = (rc_round == 5'd1);
                    end else begin
                        rc_valid_n = 1'b0;
                        rc_last_n  = 1'b0;
`ifdef KECCAK_RC_SELFCHECK_EN
                        state_n    = CHECK;
`else
                        state_n    = IDLE;
`endif
                    end
                end
            end

`ifdef KECCAK_RC_SELFCHECK_EN
            CHECK: begin
                if (s != 8'h01) begin
                    err_n = 1'b1;
                end
                state_n = IDLE;
            end
`endif

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
